// File: rtl/seg_msg_pkg.sv
// Shared encodings for the segmented-display message sequencer.
package seg_msg_pkg;

    typedef enum logic [1:0] {
        MODE_LOOP     = 2'b00,
        MODE_ONESHOT  = 2'b01,
        MODE_PINGPONG = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FWD  = 2'd1,
        ST_REV  = 2'd2
    } state_e;

    localparam logic [7:0] GLYPH_BLANK = 8'h00;
    localparam logic [7:0] GLYPH_DP    = 8'h80;

endpackage

// File: rtl/seg_step_tick.sv
// Step-period down-counter: reloads period_i on clear and on every tick,
// so a tick fires period_i+1 enabled cycles after the clear.
module seg_step_tick #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] period_i,
    output logic             tick_o
);

    logic [DIV_W-1:0] cnt_q;

    assign tick_o = en_i && !clr_i && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= period_i;
        end else if (en_i) begin
            cnt_q <= (cnt_q == '0) ? period_i : cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/seg_msg_sequencer.sv
// Steps a glyph message out to a 7-segment display in loop, one-shot or
// ping-pong order at a programmable rate.
module seg_msg_sequencer
    import seg_msg_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int SEG_W   = 8,
    parameter int DIV_W   = 24
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [$clog2(MAX_LEN)-1:0] wr_addr,
    input  logic [SEG_W-1:0]           wr_data,
    input  logic [$clog2(MAX_LEN):0]   cfg_len,
    input  logic [DIV_W-1:0]           cfg_div,
    input  logic [1:0]                 cfg_mode,
    input  logic                       start,
    input  logic                       stop,
    output logic [SEG_W-1:0]           seg_out,
    output logic [$clog2(MAX_LEN)-1:0] idx,
    output logic                       busy,
    output logic                       done
);

    localparam int AW = $clog2(MAX_LEN);
    localparam logic [AW:0]   LEN_MAX = (AW+1)'(MAX_LEN);
    localparam logic [AW:0]   LEN_ONE = (AW+1)'(1);
    localparam logic [AW:0]   LEN_TWO = (AW+1)'(2);
    localparam logic [AW-1:0] IDX_ONE = AW'(1);

    logic [SEG_W-1:0] mem_q [MAX_LEN];

    state_e           state_q;
    logic [AW-1:0]    idx_q;
    logic [SEG_W-1:0] seg_q;
    logic             done_q;
    logic [AW:0]      len_q;
    logic [DIV_W-1:0] div_q;
    logic [1:0]       mode_q;

    logic             start_ok;
    logic             tick;
    logic [AW:0]      len_c;
    logic [AW:0]      len_m2;
    logic             last_c;
    state_e           nxt_state_c;
    logic [AW-1:0]    nxt_idx_c;
    logic             fin_c;

    assign start_ok = start && (cfg_len != '0);
    assign len_c    = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;
    assign len_m2   = len_q - LEN_TWO;
    assign last_c   = ({1'b0, idx_q} == (len_q - LEN_ONE));

    assign busy    = (state_q != ST_IDLE);
    assign seg_out = seg_q;
    assign idx     = idx_q;
    assign done    = done_q;

    // A start reloads the divider from the live cfg_div since the latched copy
    // only becomes valid the cycle after.
    seg_step_tick #(.DIV_W(DIV_W)) u_tick (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (start_ok || stop),
        .en_i     (busy),
        .period_i (start_ok ? cfg_div : div_q),
        .tick_o   (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_LEN; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        nxt_state_c = state_q;
        nxt_idx_c   = idx_q;
        fin_c       = 1'b0;
        case (state_q)
            ST_FWD: begin
                if (!last_c) begin
                    nxt_idx_c = idx_q + IDX_ONE;
                end else begin
                    case (mode_q)
                        MODE_ONESHOT: begin
                            nxt_state_c = ST_IDLE;
                            nxt_idx_c   = '0;
                            fin_c       = 1'b1;
                        end
                        MODE_PINGPONG: begin
                            if (len_q == LEN_ONE) begin
                                nxt_idx_c = '0;
                            end else begin
                                nxt_state_c = ST_REV;
                                nxt_idx_c   = len_m2[AW-1:0];
                            end
                        end
                        default: nxt_idx_c = '0;
                    endcase
                end
            end
            ST_REV: begin
                if (idx_q != '0) begin
                    nxt_idx_c = idx_q - IDX_ONE;
                end else begin
                    nxt_state_c = ST_FWD;
                    nxt_idx_c   = IDX_ONE;
                end
            end
            default: ;
        endcase
    end

    // Glyph is fetched from the computed next index, so seg_out and idx land together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            seg_q   <= '0;
            done_q  <= 1'b0;
            len_q   <= '0;
            div_q   <= '0;
            mode_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (stop) begin
                state_q <= ST_IDLE;
                idx_q   <= '0;
                seg_q   <= SEG_W'(GLYPH_BLANK);
            end else if (start_ok) begin
                len_q   <= len_c;
                div_q   <= cfg_div;
                mode_q  <= cfg_mode;
                state_q <= ST_FWD;
                idx_q   <= '0;
                seg_q   <= mem_q[0];
            end else if (busy && tick) begin
                state_q <= nxt_state_c;
                idx_q   <= nxt_idx_c;
                seg_q   <= (nxt_state_c == ST_IDLE) ? SEG_W'(GLYPH_BLANK) : mem_q[nxt_idx_c];
                done_q  <= fin_c;
            end
        end
    end

endmodule

// File: doc/seg_msg_sequencer.md
SEG_MSG_SEQUENCER -- requirements
Module: seg_msg_sequencer

Interface
REQ-001 SHALL have parameter MAX_LEN, default 16, meaning glyph memory depth (power of two, >=2).
REQ-002 SHALL have parameter SEG_W, default 8, meaning glyph width (bit7 dp, bits6:0 segments a-g).
REQ-003 SHALL have parameter DIV_W, default 24, meaning step-divider width; AW = clog2(MAX_LEN).
REQ-004 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port wr_en  in  1  glyph memory write strobe.
REQ-007 SHALL have port wr_addr  in  AW  glyph write address.
REQ-008 SHALL have port wr_data  in  SEG_W  glyph write data.
REQ-009 SHALL have port cfg_len  in  AW+1  message length in glyphs.
REQ-010 SHALL have port cfg_div  in  DIV_W  step period minus one, in clk cycles.
REQ-011 SHALL have port cfg_mode  in  2  00 LOOP, 01 ONESHOT, 10 PINGPONG, 11 treated as LOOP.
REQ-012 SHALL have port start  in  1  single-cycle start/restart request.
REQ-013 SHALL have port stop  in  1  single-cycle abort request.
REQ-014 SHALL have port seg_out  out  SEG_W  registered glyph driving display.
REQ-015 SHALL have port idx  out  AW  index of glyph on seg_out.
REQ-016 SHALL have port busy  out  1  high in FWD or REV.
REQ-017 SHALL have port done  out  1  one-cycle pulse at ONESHOT completion.

Function
REQ-018 SHALL implement states IDLE, FWD, REV; busy = (state != IDLE).
REQ-019 SHALL latch cfg_len (clamped to MAX_LEN), cfg_div, cfg_mode on accepted start; later cfg changes SHALL not affect the run.
REQ-020 start with cfg_len==0 SHALL be ignored (stay IDLE, no done).
REQ-021 Accepted start in cycle N SHALL give, in N+1: state FWD, idx 0, seg_out = mem[0], divider cleared; start while busy SHALL restart identically.
REQ-022 Step tick SHALL occur every cfg_div+1 cycles after the start cycle; cfg_div==0 steps every cycle.
REQ-023 On tick, seg_out and idx SHALL update together to the next index in the cycle after the tick.
REQ-024 FWD, idx<len-1: idx+1.
REQ-025 FWD, idx==len-1: LOOP -> idx 0; ONESHOT -> IDLE, seg_out 0, idx 0, done=1 for one cycle; PINGPONG -> REV, idx len-2 (len==1: stay FWD, idx 0).
REQ-026 REV, idx>0: idx-1; REV, idx==0: FWD, idx 1.
REQ-027 stop SHALL force IDLE, seg_out 0, idx 0, no done, next cycle; stop and start same cycle: stop wins.
REQ-028 In IDLE seg_out SHALL be 0.
REQ-029 Glyph writes SHALL be accepted in every state; write to current idx SHALL appear on seg_out only at next step or restart.
REQ-030 Memory read SHALL be combinational from registered next index so seg_out needs no extra latency.

Reset
REQ-031 rst SHALL set state IDLE, seg_out 0, idx 0, busy 0, done 0, divider 0, latched cfg 0, all glyph entries 0.
REQ-032 rst SHALL override start, stop, wr_en in the same cycle, including mid-run.

Structure
REQ-033 Package seg_msg_pkg SHALL hold mode encoding, state encoding, GLYPH_BLANK (00h), GLYPH_DP (80h).
REQ-034 Sub-module seg_step_tick SHALL implement the DIV_W down-counter with clear input and tick output.

Verification
REQ-035 Load S,E,n,O (5Bh,4Fh,15h,7Eh), len 4, div 2, LOOP, start -> seg_out 5Bh,4Fh,15h,7Eh,5Bh each held 3 cycles.
REQ-036 Same glyphs, ONESHOT, div 0 -> 5Bh,4Fh,15h,7Eh then seg_out 0, done high exactly one cycle, busy low.
REQ-037 len 4, PINGPONG, div 0 -> idx 0,1,2,3,2,1,0,1; len 1 PINGPONG -> idx constant 0.
REQ-038 Running, start and stop asserted same cycle -> IDLE, seg_out 0, done 0; later start -> idx 0 next cycle.
REQ-039 Running, rst at idx 2 -> all outputs 0 next cycle; start with cfg_len 0 -> busy stays 0.
REQ-040 Running LOOP, write 80h to current idx -> seg_out unchanged until that idx is next displayed, then 80h.
